// File: rtl/reg_file_wb.sv
// Register file feeding the 8-bit ALU. Writes pass through a one-stage writeback
// register. Reads are combinational and forward from that stage, so a write is visible one cycle later.
module reg_file_wb #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] super_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          flag_we,
  input  logic          zero_in,
  input  logic          stall,
  output logic          zero_flag,
  output logic          wr_drop
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs [NREG];
  logic          pend_valid_reg;
  logic [AW-1:0] pend_addr_reg;
  logic [DW-1:0] pend_data_reg;
  logic          zero_flag_reg;
  logic          wr_drop_reg;

  // The array must clear on reset, so it is held in flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (!stall && pend_valid_reg) begin
      regs[pend_addr_reg] <= pend_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_data_reg  <= '0;
      wr_drop_reg    <= 1'b0;
      zero_flag_reg  <= 1'b0;
    end else begin
      if (!stall) begin
        pend_valid_reg <= wr_en;
        pend_addr_reg  <= wr_addr;
        pend_data_reg  <= wr_data;
      end else if (wr_en) begin
        wr_drop_reg <= 1'b1;
      end
      if (flag_we) begin
        zero_flag_reg <= zero_in;
      end
    end
  end

  // Forward only from the registered stage; wr_data never reaches the read ports
  // combinationally, which keeps the ALU path loop-free.
  assign rs_data    = (pend_valid_reg && pend_addr_reg == rs_addr) ? pend_data_reg : regs[rs_addr];
  assign rt_data    = (pend_valid_reg && pend_addr_reg == rt_addr) ? pend_data_reg : regs[rt_addr];
  assign super_data = (pend_valid_reg && pend_addr_reg == '0)      ? pend_data_reg : regs[0];

  assign zero_flag = zero_flag_reg;
  assign wr_drop   = wr_drop_reg;

endmodule
